// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending transaction controller.
package vend_pkg;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } vend_state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_50   = 2'b01;
  localparam logic [1:0] COIN_100  = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  // Credit value of a coin code in 50-cent units; invalid and idle codes are worth nothing.
  function automatic logic [1:0] coin_value(input logic [1:0] code);
    logic [1:0] v;
    case (code)
      COIN_50:  v = 2'd1;
      COIN_100: v = 2'd2;
      default:  v = 2'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_timeout.sv
// Inactivity counter: while run is high it counts cycles and fires a
// one-cycle expire pulse in the cycle the count sits at TIMEOUT-1.
module vend_timeout #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  assign expire_o = run_i && (count_q == LAST);

  // Next count: clear wins, wrap to zero on expiry, otherwise advance while running.
  always_comb begin
    count_d = count_q;
    if (clear_i || expire_o) begin
      count_d = '0;
    end else if (run_i) begin
      count_d = count_q + TW'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: collects coin credit, runs the dispenser
// handshake, then pays change one 50c unit per hopper acknowledge.
//
// Handshakes: disp_req_o / chg_req_o are high for as long as the FSM sits in
// DISPENSE / CHANGE; each cycle the matching ack is sampled high at a clk edge
// completes one transfer (the whole vend, or one change unit). Requests are
// decoded from the state register only, so acks never combinationally affect
// any output.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int CW      = 3,
  parameter int PRICE   = 3,
  parameter int TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    coin_i,
  input  logic          cancel_i,
  input  logic          disp_ack_i,
  input  logic          chg_ack_i,
  output logic          disp_req_o,
  output logic          chg_req_o,
  output logic          coin_en_o,
  output logic [CW-1:0] credit_o,
  output logic          vend_done_o,
  output logic          coin_rej_o
);

  localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  vend_state_t   state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          vend_done_q, vend_done_d;
  logic          coin_rej_q, coin_rej_d;

  logic [CW-1:0] coin_val;
  logic [CW-1:0] sum;
  logic          coin_ok;
  logic          timer_run;
  logic          timer_clear;
  logic          timer_expire;

  // Coins are only accepted while collecting; the sum cannot overflow since
  // credit stays below PRICE in COLLECT and PRICE+2 fits in CW bits.
  assign coin_val = CW'(coin_value(coin_i));
  assign coin_ok  = (state_q == COLLECT) && (coin_val != '0);
  assign sum      = credit_q + coin_val;

  assign timer_run   = (state_q == COLLECT) && (credit_q != '0);
  assign timer_clear = coin_ok || cancel_i || (state_q != COLLECT);

  vend_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_i    (timer_run),
    .clear_i  (timer_clear),
    .expire_o (timer_expire)
  );

  // Next-state and credit update; a coin always takes priority over cancel and expiry.
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    vend_done_d = 1'b0;
    coin_rej_d  = (coin_i == COIN_BAD) || ((coin_i != COIN_NONE) && (state_q != COLLECT));
    case (state_q)
      COLLECT: begin
        if (coin_ok) begin
          credit_d = sum;
        end
        if (coin_ok && (sum >= PRICE_C)) begin
          state_d = DISPENSE;
        end else if (cancel_i && (sum != '0)) begin
          state_d = CHANGE;
        end else if (timer_expire && !coin_ok) begin
          state_d = CHANGE;
        end
      end
      DISPENSE: begin
        if (disp_ack_i) begin
          credit_d    = credit_q - PRICE_C;
          vend_done_d = 1'b1;
          state_d     = (credit_q != PRICE_C) ? CHANGE : COLLECT;
        end
      end
      CHANGE: begin
        if (chg_ack_i && (credit_q != '0)) begin
          credit_d = credit_q - ONE_C;
          if (credit_q == ONE_C) begin
            state_d = COLLECT;
          end
        end
      end
      default: begin
        state_d  = COLLECT;
        credit_d = '0;
      end
    endcase
  end

  // State, credit and pulse registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      credit_q    <= '0;
      vend_done_q <= 1'b0;
      coin_rej_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      vend_done_q <= vend_done_d;
      coin_rej_q  <= coin_rej_d;
    end
  end

  assign coin_en_o   = (state_q == COLLECT);
  assign disp_req_o  = (state_q == DISPENSE);
  assign chg_req_o   = (state_q == CHANGE);
  assign credit_o    = credit_q;
  assign vend_done_o = vend_done_q;
  assign coin_rej_o  = coin_rej_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: directed scenarios followed by random traffic, all
// compared every cycle against a cycle-level behavioural model.
module tb_vend_ctrl;

  localparam int CW      = 3;
  localparam int PRICE   = 3;
  localparam int TIMEOUT = 16;

  localparam int PH_COLLECT  = 0;
  localparam int PH_DISPENSE = 1;
  localparam int PH_CHANGE   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    coin_i = 2'b00;
  logic          cancel_i = 1'b0;
  logic          disp_ack_i = 1'b0;
  logic          chg_ack_i = 1'b0;
  logic          disp_req_o;
  logic          chg_req_o;
  logic          coin_en_o;
  logic [CW-1:0] credit_o;
  logic          vend_done_o;
  logic          coin_rej_o;

  int n_checks = 0;
  int n_errors = 0;

  // model of the transaction as plain integers
  int m_phase  = PH_COLLECT;
  int m_credit = 0;
  int m_idle   = 0;
  int m_done   = 0;
  int m_rej    = 0;

  // clock / reset block
  always #5 clk = ~clk;

  vend_ctrl #(
    .CW      (CW),
    .PRICE   (PRICE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coin_i      (coin_i),
    .cancel_i    (cancel_i),
    .disp_ack_i  (disp_ack_i),
    .chg_ack_i   (chg_ack_i),
    .disp_req_o  (disp_req_o),
    .chg_req_o   (chg_req_o),
    .coin_en_o   (coin_en_o),
    .credit_o    (credit_o),
    .vend_done_o (vend_done_o),
    .coin_rej_o  (coin_rej_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the vending rules, applied to the model.
  task automatic model_step(input int coin, input int cancel, input int dack, input int cack,
                            input int rst);
    int val;
    int nc;
    if (rst != 0) begin
      m_phase  = PH_COLLECT;
      m_credit = 0;
      m_idle   = 0;
      m_done   = 0;
      m_rej    = 0;
      return;
    end
    m_done = 0;
    m_rej  = (coin == 3 || (coin != 0 && m_phase != PH_COLLECT)) ? 1 : 0;
    case (m_phase)
      PH_COLLECT: begin
        val = (coin == 1) ? 1 : (coin == 2) ? 2 : 0;
        nc  = m_credit + val;
        if (val > 0 && nc >= PRICE) begin
          m_credit = nc;
          m_phase  = PH_DISPENSE;
          m_idle   = 0;
        end else if (cancel != 0 && nc > 0) begin
          m_credit = nc;
          m_phase  = PH_CHANGE;
          m_idle   = 0;
        end else if (val > 0) begin
          m_credit = nc;
          m_idle   = 0;
        end else if (m_credit > 0) begin
          if (m_idle == TIMEOUT - 1) begin
            m_phase = PH_CHANGE;
            m_idle  = 0;
          end else begin
            m_idle++;
          end
        end
      end
      PH_DISPENSE: begin
        if (dack != 0) begin
          m_credit = m_credit - PRICE;
          m_done   = 1;
          m_phase  = (m_credit > 0) ? PH_CHANGE : PH_COLLECT;
        end
      end
      default: begin
        if (cack != 0 && m_credit > 0) begin
          m_credit--;
          if (m_credit == 0) m_phase = PH_COLLECT;
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    check("credit",    32'(credit_o),    32'(m_credit));
    check("disp_req",  32'(disp_req_o),  32'(m_phase == PH_DISPENSE));
    check("chg_req",   32'(chg_req_o),   32'(m_phase == PH_CHANGE));
    check("coin_en",   32'(coin_en_o),   32'(m_phase == PH_COLLECT));
    check("vend_done", 32'(vend_done_o), 32'(m_done));
    check("coin_rej",  32'(coin_rej_o),  32'(m_rej));
  endtask

  // driver: apply inputs for one edge, advance the model, check after the edge
  task automatic step(input int coin, input int cancel, input int dack, input int cack,
                      input int rst);
    coin_i     = 2'(coin);
    cancel_i   = (cancel != 0);
    disp_ack_i = (dack != 0);
    chg_ack_i  = (cack != 0);
    rst_n      = (rst == 0);
    @(posedge clk);
    model_step(coin, cancel, dack, cack, rst);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
  endtask

  initial begin
    int lat;
    int quiet;
    int r;
    int coin;
    int cancel;

    do_reset();
    check("reset_credit", 32'(credit_o), 32'd0);
    check("reset_coin_en", 32'(coin_en_o), 32'd1);

    // three 50c coins, two cycles apart, then a late dispenser ack
    step(1, 0, 0, 0, 0); idle(1);
    step(1, 0, 0, 0, 0); idle(1);
    step(1, 0, 0, 0, 0);
    check("vend_req_after_3rd", 32'(disp_req_o), 32'd1);
    idle(2);
    step(0, 0, 1, 0, 0);
    check("vend_done_pulse", 32'(vend_done_o), 32'd1);
    idle(1);

    // two 1-EUR coins: vend, then one unit of change
    step(2, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0);
    check("credit_4", 32'(credit_o), 32'd4);
    step(0, 0, 1, 0, 0);
    check("change_credit_1", 32'(credit_o), 32'd1);
    step(0, 0, 0, 1, 0);
    idle(1);

    // 50c then cancel; second cancel at zero credit has no effect
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    check("cancel_zero_coin_en", 32'(coin_en_o), 32'd1);

    // inactivity refund: count cycles from the coin edge until chg_req rises
    step(2, 0, 0, 0, 0);
    lat = 0;
    while (chg_req_o !== 1'b1 && lat < 3 * TIMEOUT) begin
      step(0, 0, 0, 0, 0);
      lat++;
    end
    check("timeout_latency", 32'(lat), 32'(TIMEOUT));
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    check("timeout_refund_done", 32'(credit_o), 32'd0);

    // a coin in the expiry cycle is accepted instead of refunding
    step(2, 0, 0, 0, 0);
    idle(TIMEOUT - 1);
    step(1, 0, 0, 0, 0);
    check("expiry_coin_credit", 32'(credit_o), 32'd3);
    check("expiry_coin_disp", 32'(disp_req_o), 32'd1);

    // coin during DISPENSE rejected; then bad code while collecting
    step(1, 0, 0, 0, 0);
    check("rej_in_dispense", 32'(coin_rej_o), 32'd1);
    step(0, 0, 1, 0, 0);
    step(3, 0, 0, 0, 0);
    check("rej_bad_code", 32'(coin_rej_o), 32'd1);

    // cancel together with 50c at credit 2 goes to DISPENSE
    step(2, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check("cancel_coin_disp", 32'(disp_req_o), 32'd1);
    step(0, 0, 1, 0, 0);

    // reset during CHANGE with credit 1
    step(2, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check("pre_reset_chg", 32'(chg_req_o), 32'd1);
    step(0, 0, 0, 0, 1);
    check("mid_reset_credit", 32'(credit_o), 32'd0);
    check("mid_reset_coin_en", 32'(coin_en_o), 32'd1);
    check("mid_reset_chg", 32'(chg_req_o), 32'd0);

    // random traffic with occasional quiet windows to reach the timeout
    quiet = 0;
    for (int i = 0; i < 4000; i++) begin
      coin   = 0;
      cancel = 0;
      if (quiet > 0) begin
        quiet--;
      end else begin
        r = $urandom_range(0, 99);
        coin   = (r < 15) ? 1 : (r < 25) ? 2 : (r < 30) ? 3 : 0;
        cancel = ($urandom_range(0, 19) == 0) ? 1 : 0;
        if ($urandom_range(0, 39) == 0) quiet = $urandom_range(10, 25);
      end
      step(coin, cancel, ($urandom_range(0, 2) == 0) ? 1 : 0,
           ($urandom_range(0, 2) == 0) ? 1 : 0,
           ($urandom_range(0, 399) == 0) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
